uart_tx_piso: RTL and testbench

- Parallel-in/serial-out UART transmitter for one Hydra port.
- Accepts a WIDTH-bit packet from the Hydra controller through a load pulse, then serializes it LSB-first inside a start/stop frame.
- Reports busy back to the controller.
- Four instances sit between the Hydra controller and the chip PISO pads; each is the transmit end of the link whose receive end feeds the RX UARTs.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_piso_if.sv | 14 +
 rtl/uart_baud_tick.sv | 23 ++
 rtl/uart_tx_piso.sv | 102 ++++++++++
 tb/tb_uart_tx_piso.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and line levels shared by the Hydra TX and RX UARTs.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_piso_if.sv
// uart_tx_piso_if: load/status handshake and serial line between the Hydra controller and one TX UART.
interface uart_tx_piso_if #(parameter int WIDTH = 64);

    logic [WIDTH-1:0] tx_data;
    logic             ld_tx_data;
    logic             tx_enable;
    logic             tx_out;
    logic             tx_busy;
    logic             tx_overrun;

    modport master (output tx_data, ld_tx_data, tx_enable, input tx_out, tx_busy, tx_overrun);
    modport slave  (input tx_data, ld_tx_data, tx_enable, output tx_out, tx_busy, tx_overrun);

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: counts CLK_PER_BIT cycles per serial bit; held at zero while run is low.
module uart_baud_tick #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic bit_done
);

    localparam logic [7:0] LAST = 8'(CLK_PER_BIT - 1);

    logic [7:0] cnt;

    assign bit_done = run && cnt == LAST;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            cnt <= '0;
        else
            cnt <= (!run || bit_done) ? '0 : cnt + 8'd1;

endmodule

// File: rtl/uart_tx_piso.sv
// uart_tx_piso: Hydra PISO UART transmitter, LSB-first packet in a start/stop frame.
// Define UART_TX_PARITY_EN to insert an odd-parity bit between data and stop.
module uart_tx_piso
    import uart_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int CLK_PER_BIT = 4
) (
    input logic           clk,
    input logic           reset_n,
    uart_tx_piso_if.slave bus
);

    localparam int BW = $clog2(WIDTH + 1);

    uart_tx_state_t   state, state_d;
    logic [WIDTH-1:0] sr, sr_d;
    logic [BW-1:0]    bit_cnt, bit_cnt_d;
    logic             bit_done, load, last_bit;
    logic             out_d, busy_d, ovr_d;

    assign load     = bus.ld_tx_data && !bus.tx_busy && bus.tx_enable && state == IDLE;
    assign last_bit = bit_cnt == BW'(WIDTH - 1);

    uart_baud_tick #(.CLK_PER_BIT(CLK_PER_BIT)) u_baud (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (state != IDLE),
        .bit_done (bit_done)
    );

`ifdef UART_TX_PARITY_EN
    logic par;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            par <= 1'b0;
        else if (load)
            par <= ~^bus.tx_data;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state          <= IDLE;
            sr             <= '0;
            bit_cnt        <= '0;
            bus.tx_out     <= UART_IDLE_LEVEL;
            bus.tx_busy    <= 1'b0;
            bus.tx_overrun <= 1'b0;
        end else begin
            state          <= state_d;
            sr             <= sr_d;
            bit_cnt        <= bit_cnt_d;
            bus.tx_out     <= out_d;
            bus.tx_busy    <= busy_d;
            bus.tx_overrun <= ovr_d;
        end

    always_comb begin
        state_d   = state;
        sr_d      = sr;
        bit_cnt_d = bit_cnt;
        case (state)
            IDLE:  if (load) begin
                       state_d = START;
                       sr_d    = bus.tx_data;
                   end
            START: if (bit_done) state_d = DATA;
            DATA:  if (bit_done) begin
                       sr_d      = sr >> 1;
                       bit_cnt_d = last_bit ? '0 : bit_cnt + BW'(1);
`ifdef UART_TX_PARITY_EN
                       if (last_bit) state_d = PARITY;
`else
                       if (last_bit) state_d = STOP;
`endif
                   end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) state_d = STOP;
`endif
            STOP:  if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state to line up with it.
    always_comb begin
        out_d = UART_IDLE_LEVEL;
        case (state_d)
            START:  out_d = UART_START_BIT;
            DATA:   out_d = sr_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: out_d = par;
`endif
            STOP:   out_d = UART_STOP_BIT;
            default: out_d = UART_IDLE_LEVEL;
        endcase
        busy_d = state_d != IDLE;
        ovr_d  = bus.ld_tx_data && bus.tx_busy;
    end

endmodule

// File: tb/tb_uart_tx_piso.sv
// tb_uart_tx_piso: directed stimulus with a frame-decoding monitor checked against an expected-packet queue.
module tb_uart_tx_piso;

    localparam int W = 64;
`ifdef UART_TX_PARITY_EN
    localparam int CPB = 1;
    localparam int PB  = 1;
`else
    localparam int CPB = 2;
    localparam int PB  = 0;
`endif
    localparam int NB = W + 2 + PB;
    localparam int FL = NB * CPB;

    typedef struct {
        logic [W-1:0] d;
        logic         p;
    } exp_t;

    logic clk, reset_n;
    uart_tx_piso_if #(.WIDTH(W)) bus ();

    uart_tx_piso #(.WIDTH(W), .CLK_PER_BIT(CPB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0, errors = 0;
    exp_t sb[$];
    int   frames_done = 0, aborts = 0, nexp = 0;
    int   busy_run = 0, last_busy = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame monitor: samples every cycle of every bit, pops the expected packet at frame end.
    logic [NB-1:0] f;
    logic          glitch, ab;
    exp_t          e;
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && bus.tx_out === 1'b0) begin
                f = '0;
                glitch = 1'b0;
                ab = 1'b0;
                for (int b = 0; b < NB && !ab; b++)
                    for (int j = 0; j < CPB && !ab; j++) begin
                        if (b != 0 || j != 0) @(negedge clk);
                        if (reset_n !== 1'b1) ab = 1'b1;
                        else if (j == 0) f[b] = bus.tx_out;
                        else if (bus.tx_out !== f[b]) glitch = 1'b1;
                    end
                chk("frame_expected", W'(sb.size() != 0), W'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    if (ab) aborts++;
                    else begin
                        chk("start_bit", W'(f[0]), W'(0));
                        chk("data_word", f[W:1], e.d);
`ifdef UART_TX_PARITY_EN
                        chk("parity_bit", W'(f[W+1]), W'(e.p));
`endif
                        chk("stop_bit", W'(f[NB-1]), W'(1));
                        chk("bit_stable", W'(glitch), W'(0));
                        frames_done++;
                    end
                end
            end
        end
    end

    always @(negedge clk)
        if (reset_n !== 1'b1) busy_run = 0;
        else if (bus.tx_busy === 1'b1) busy_run++;
        else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run = 0;
        end

    task automatic load(input logic [W-1:0] d, input bit push);
        @(posedge clk);
        #1;
        bus.ld_tx_data = 1'b1;
        bus.tx_data = d;
        if (push) begin
            sb.push_back('{d: d, p: ~^d});
            nexp++;
        end
        @(posedge clk);
        #1;
        bus.ld_tx_data = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        while ((frames_done < nexp || bus.tx_busy !== 1'b0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, "_timeout"}, W'(n < 4000), W'(1));
        chk({tag, "_busy_len"}, W'(last_busy), W'(FL));
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        bus.tx_data = '0;
        bus.ld_tx_data = 1'b0;
        bus.tx_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vals", W'({bus.tx_out, bus.tx_busy, bus.tx_overrun}), W'(3'b100));
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle", W'({bus.tx_out, bus.tx_busy, bus.tx_overrun}), W'(3'b100));
        end

        bus.tx_enable = 1'b1;
        load(64'hA5A5_0000_FFFF_1234, 1);
        chk("start_on_load_edge", W'({bus.tx_out, bus.tx_busy}), W'(2'b01));
        wait_frame("main");

        // Rejected load in mid-frame, then a load in the first non-busy cycle.
        load(64'h0123_4567_89AB_CDEF, 1);
        repeat (10) @(posedge clk);
        #1;
        bus.ld_tx_data = 1'b1;
        bus.tx_data = 64'hFFFF_0000_FFFF_0000;
        @(posedge clk);
        #1;
        bus.ld_tx_data = 1'b0;
        chk("ovr_pulse_high", W'(bus.tx_overrun), W'(1));
        @(posedge clk);
        #1;
        chk("ovr_pulse_low", W'(bus.tx_overrun), W'(0));
        n = 0;
        while (bus.tx_busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_wait", W'(n < 4000), W'(1));
        chk("b2b_prev_done", W'(frames_done), W'(nexp));
        bus.tx_data = 64'h8000_0000_0000_0001;
        bus.ld_tx_data = 1'b1;
        sb.push_back('{d: 64'h8000_0000_0000_0001, p: 1'b1});
        nexp++;
        @(posedge clk);
        #1;
        bus.ld_tx_data = 1'b0;
        chk("b2b_start", W'({bus.tx_out, bus.tx_busy}), W'(2'b01));
        wait_frame("b2b");

        // Disabled transmitter ignores loads silently.
        bus.tx_enable = 1'b0;
        load(64'h1, 0);
        repeat (5) begin
            @(negedge clk);
            chk("disabled_idle", W'({bus.tx_out, bus.tx_busy, bus.tx_overrun}), W'(3'b100));
        end
        chk("disabled_no_frame", W'(frames_done), W'(nexp));

        // Dropping enable mid-frame does not truncate it.
        bus.tx_enable = 1'b1;
        load(64'h0F0F_1234_5678_F0F0, 1);
        repeat (30) @(posedge clk);
        #1;
        bus.tx_enable = 1'b0;
        wait_frame("enable_drop");
        bus.tx_enable = 1'b1;

        // Reset mid-frame abandons the frame immediately.
        load(64'hDEAD_BEEF_CAFE_F00D, 1);
        repeat (50) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midreset_out", W'({bus.tx_out, bus.tx_busy, bus.tx_overrun}), W'(3'b100));
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        nexp--;
        chk("midreset_aborted", W'(aborts), W'(1));
        chk("midreset_sb_empty", W'(sb.size()), W'(0));
        load(64'h5555_AAAA_3C3C_C3C3, 1);
        wait_frame("after_reset");

`ifdef UART_TX_PARITY_EN
        load(64'h1, 1);
        chk("par1_expect", W'(sb[sb.size()-1].p), W'(0));
        wait_frame("parity_1");
        load(64'h3, 1);
        chk("par3_expect", W'(sb[sb.size()-1].p), W'(1));
        wait_frame("parity_3");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
